seg7_bcd_scan: RTL
==================

# seg7_bcd_scan

Upstream driver for the four-digit seven-segment display. It accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 converter. It then time-multiplexes those digits onto one shared 4-bit digit bus plus an active-low anode select. Its `dig` output feeds the combinational digit decoder directly; that decoder turns codes 0-9 into glyphs and codes 10-15 into all-segments-off.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit stays selected (1 kHz per digit at 50 MHz); must be ≥ 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  one-cycle strobe; captures `bin` when `busy`=0.
- `bin`  in  14  unsigned binary value to display.
- `lz_en`  in  1  leading-zero blanking enable; sampled live every cycle.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  last committed value exceeded 9999.
- `dig`  out  4  digit code to the decoder; 0-9 = digit, 4'hF = blank.
- `an`  out  4  active-low anode select; bit 0 = least-significant digit.

## Operation
- Converter FSM states:
  - IDLE → CONV on `load`=1 while `busy`=0. The FSM captures `bin` into the shift register and clears the BCD accumulator.
  - CONV performs 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts the {bcd, bin} register left by 1.
  - CONV → IDLE on the 14th iteration. The final BCD value commits to the display register on that same edge.
- Overflow: if the captured `bin` > 9999, the 14 cycles still elapse. The commit writes BCD 16'h9999 and sets `ovf`=1. Any in-range commit clears `ovf`.
- `load` while `busy`=1 is ignored and not queued.
- The display register holds the previous value for the whole conversion, so no partial digits reach the display.
- Scanner:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - The 2-bit digit index increments modulo 4 on each prescaler wrap (3 → 0).
- Output generation:
  - `an` has exactly one bit low: the indexed one.
  - `dig` is the display-register nibble at the index.
- Leading-zero blanking, when `lz_en`=1: a nibble is output as 4'hF if it is 0 and all higher nibbles are 0. Index 0 is never blanked, so a value of 0 shows a single "0".
- `an` and `dig` are registered together from the same index, so they change on the same edge (no ghosting).

## Timing
- Reset values: `an`=4'b1111, `dig`=4'hF, `busy`=0, `ovf`=0. Display register, index and prescaler are all 0.
- First edge after `rst` deasserts: `an`=4'b1110, `dig`=4'h0.
- Each digit is held exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- `load` sampled at edge T:
  - `busy`=1 after edge T.
  - Shifts occur on edges T+1..T+14; commit and `busy`=0 happen after edge T+14.
  - `ovf` updates at the commit edge.
  - `dig` shows the new value from edge T+15 for the currently selected digit.
- Minimum load-to-load spacing is 15 cycles. A `load` at edge T+14 is ignored because `busy` is still 1 before that edge.
- `rst` during CONV aborts the conversion: `busy`=0, display register 0, `ovf`=0, and the next `load` is accepted normally.
- Scanning continues uninterrupted during conversion.

## Structure
- Package `seg7_pkg` holds:
  - `N_DIG`=4, `BIN_W`=14, `BCD_W`=16, `MAX_BCD`=16'h9999, `BLANK_CODE`=4'hF;
  - typedef `bcd4_t` (4 × 4-bit nibble array).
- Sub-module `bin2bcd_seq` contains the IDLE/CONV FSM, the iteration counter, the shift/add-3 datapath, the overflow compare and `busy`.
- The top level holds the display register, prescaler, index, blanking logic and output registers.
- The digit decoder is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold `rst` 3 cycles → `an`=1111, `dig`=F, `busy`=0. First edge after release → `an`=1110, `dig`=0.
- REFRESH_DIV=4, `lz_en`=0, `load` `bin`=1234 → `busy` high exactly 14 cycles. Then `dig`/`an` sequence 4/1110, 3/1101, 2/1011, 1/0111, each for 4 cycles, repeating.
- `lz_en`=1, load 7 → digits 7,F,F,F. Load 0 → 0,F,F,F. Load 1005 → 5,0,0,1 (interior zeros are not blanked).
- Load 12000 → `ovf`=1 at commit, digits 9,9,9,9. Then load 5 → `ovf`=0, digits 5,0,0,0 with `lz_en`=0.
- Load 1234, then load 42 at 5 cycles after the first `load` → second load ignored, commit is 1234, `busy` drops 14 cycles after the first `load`.
- Assert `rst` 7 cycles into a conversion of 9999 → `busy`=0, display shows 0. A following load of 321 commits 321 after 14 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the seven-segment BCD scan driver.
package seg7_pkg;

   localparam int          N_DIG      = 4;
   localparam int          BIN_W      = 14;
   localparam int          BCD_W      = 16;
   localparam logic [15:0] MAX_BCD    = 16'h9999;
   localparam logic [3:0]  BLANK_CODE = 4'hF;

   // Largest binary value that fits in four decimal digits.
   localparam logic [13:0] MAX_BIN    = 14'd9999;

   // One shift per input bit.
   localparam int          ITERS      = BIN_W;

   typedef logic [3:0]              nibble_t;
   typedef nibble_t [N_DIG-1:0]     bcd4_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } conv_state_e;

   // Double-dabble correction: any nibble of 5 or more gets 3 added so the
   // following left shift carries correctly into the next decimal digit.
   function automatic bcd4_t add3_all(input bcd4_t b);
      bcd4_t r;
      r = b;
      for (int i = 0; i < N_DIG; i++) begin
         if (b[i] >= 4'd5) r[i] = b[i] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
// Handshake: load_i is a one-cycle strobe honoured only in IDLE; while the
// FSM is in CONV further strobes are dropped. commit_o pulses for exactly
// one cycle, on the final iteration, with result_o holding the final value.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [BIN_W-1:0]  bin_i,
   output logic              commit_o,
   output bcd4_t             result_o,
   output logic              ovf_o,
   output conv_state_e       state_o
);

   conv_state_e          state_q;
   logic [3:0]           iter_q;
   bcd4_t                bcd_q;
   logic [BIN_W-1:0]     sh_q;
   logic                 big_q;
   logic                 ovf_q;

   bcd4_t                bcd_adj;
   logic [BCD_W+BIN_W-1:0] shifted;
   bcd4_t                bcd_d;
   logic [BIN_W-1:0]     sh_d;
   logic                 last_iter;

   // One iteration of the datapath: correct every nibble, then shift the
   // combined {bcd, bin} register left by one.
   always_comb begin
      bcd_adj   = add3_all(bcd_q);
      shifted   = {bcd_adj, sh_q} << 1;
      bcd_d     = shifted[BCD_W+BIN_W-1:BIN_W];
      sh_d      = shifted[BIN_W-1:0];
      last_iter = (state_q == ST_CONV) && (iter_q == 4'(ITERS-1));
   end

   // Out-of-range inputs still run the full 14 cycles but commit all nines.
   assign commit_o = last_iter;
   assign result_o = big_q ? bcd4_t'(MAX_BCD) : bcd_d;
   assign ovf_o    = ovf_q;
   assign state_o  = state_q;

   // Converter FSM: capture on load in IDLE, iterate in CONV, return on commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         iter_q  <= 4'd0;
         bcd_q   <= '0;
         sh_q    <= '0;
         big_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_i) begin
                  state_q <= ST_CONV;
                  iter_q  <= 4'd0;
                  bcd_q   <= '0;
                  sh_q    <= bin_i;
                  big_q   <= (bin_i > MAX_BIN);
               end
            end
            ST_CONV: begin
               bcd_q  <= bcd_d;
               sh_q   <= sh_d;
               iter_q <= iter_q + 4'd1;
               if (last_iter) begin
                  state_q <= ST_IDLE;
                  ovf_q   <= big_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg7_bcd_scan.sv
// Four-digit seven-segment scan driver: binary load, BCD conversion,
// time-multiplexed digit/anode outputs with optional leading-zero blanking.
module seg7_bcd_scan
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BIN_W-1:0]  bin,
   input  logic              lz_en,
   output logic              busy,
   output logic              ovf,
   output logic [3:0]        dig,
   output logic [3:0]        an
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   conv_state_e     conv_state;
   logic            commit;
   bcd4_t           result;

   bcd4_t           disp_q;
   logic [PW-1:0]   presc_q;
   logic [1:0]      idx_q;
   logic [3:0]      dig_q;
   logic [3:0]      an_q;

   logic [3:0]      dig_d;
   logic [3:0]      an_d;
   logic            hi_zero;

   bin2bcd_seq u_conv (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .bin_i    (bin),
      .commit_o (commit),
      .result_o (result),
      .ovf_o    (ovf),
      .state_o  (conv_state)
   );

   assign busy = (conv_state == ST_CONV);

   // Display register only changes at commit, so partial results never show.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q <= '0;
      end else if (commit) begin
         disp_q <= result;
      end
   end

   // Prescaler and digit index: index advances once per prescaler wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
      end else if (presc_q == PRESC_LAST) begin
         presc_q <= '0;
         idx_q   <= idx_q + 2'd1;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Select the indexed nibble, blanking it when it and every higher nibble
   // are zero; digit 0 is exempt so a zero value still shows one "0".
   always_comb begin
      hi_zero = 1'b1;
      for (int i = 0; i < N_DIG; i++) begin
         if ((i >= int'(idx_q)) && (disp_q[i] != 4'd0)) hi_zero = 1'b0;
      end
      dig_d = disp_q[idx_q];
      if (lz_en && (idx_q != 2'd0) && hi_zero) dig_d = BLANK_CODE;
      an_d = ~(4'b0001 << idx_q);
   end

   // Digit and anode are registered together so they switch on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         dig_q <= BLANK_CODE;
         an_q  <= 4'b1111;
      end else begin
         dig_q <= dig_d;
         an_q  <= an_d;
      end
   end

   assign dig = dig_q;
   assign an  = an_q;

endmodule
